// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register with stall/flush, write-back data
// select and extension, register-file write port, bypass lookups, retired count.
module wb_stage #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 4,
  parameter int                 INSTR_W   = 16,
  parameter int                 NUM_FWD   = 2,
  parameter int                 CNT_W     = 32,
  parameter int                 ZERO_EN   = 0,
  parameter int                 ZERO_REG  = 0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wbi_valid,
  input  logic                      wbi_stall,
  input  logic                      wbi_flush,
  input  logic [INSTR_W-1:0]        wbi_instr,
  input  logic [DATA_W-1:0]         wbi_alu_data,
  input  logic [DATA_W-1:0]         wbi_mem_data,
  input  logic [1:0]                wbi_sel,
  input  logic [ADDR_W-1:0]         wbi_wreg_addr,
  input  logic                      wbi_reg_wrn,
  input  logic [NUM_FWD*ADDR_W-1:0] wbi_fwd_addr,
  output logic [NUM_FWD-1:0]        wbo_fwd_hit,
  output logic [NUM_FWD*DATA_W-1:0] wbo_fwd_data,
  output logic [INSTR_W-1:0]        wbo_instr,
  output logic [ADDR_W-1:0]         wbo_wreg_addr,
  output logic [DATA_W-1:0]         wbo_wreg_data,
  output logic                      wbo_reg_wrn,
  output logic [CNT_W-1:0]          wbo_retired
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [INSTR_W-1:0] instr_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [DATA_W-1:0]  data_p0;
  logic               wrn_p0;
  logic [CNT_W-1:0]   retired_p0;

  // Byte loads extend from bit 7; DATA_W may be exactly 8, so no replication.
  function automatic logic [DATA_W-1:0] wb_select(input logic [1:0]        sel,
                                                   input logic [DATA_W-1:0] alu,
                                                   input logic [DATA_W-1:0] mem);
    logic [DATA_W-1:0] r;
    r = '0;
    case (sel)
      2'b00: r = alu;
      2'b01: r = mem;
      2'b10: begin
        r[7:0] = mem[7:0];
        for (int i = 8; i < DATA_W; i++) r[i] = mem[7];
      end
      default: r[7:0] = mem[7:0];
    endcase
    return r;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_EN != 0) && (a == ZERO_A);
  endfunction

  // MEM -> WB stage register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_p0   <= NOP_INSTR;
      addr_p0    <= '0;
      data_p0    <= '0;
      wrn_p0     <= 1'b1;
      retired_p0 <= '0;
    end else if (wbi_flush || (!wbi_stall && !wbi_valid)) begin
      instr_p0 <= NOP_INSTR;
      addr_p0  <= '0;
      data_p0  <= '0;
      wrn_p0   <= 1'b1;
    end else if (!wbi_stall) begin
      instr_p0   <= wbi_instr;
      addr_p0    <= wbi_wreg_addr;
      data_p0    <= wb_select(wbi_sel, wbi_alu_data, wbi_mem_data);
      wrn_p0     <= wbi_reg_wrn | is_zero_reg(wbi_wreg_addr);
      retired_p0 <= retired_p0 + CNT_W'(1);
    end
  end

  assign wbo_instr     = instr_p0;
  assign wbo_wreg_addr = addr_p0;
  assign wbo_wreg_data = data_p0;
  assign wbo_reg_wrn   = wrn_p0;
  assign wbo_retired   = retired_p0;

  // Bypass lookups against the registered write, zero-latency
  always_comb begin
    wbo_fwd_hit  = '0;
    wbo_fwd_data = '0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!wrn_p0 && (wbi_fwd_addr[i*ADDR_W +: ADDR_W] == addr_p0) &&
          !is_zero_reg(wbi_fwd_addr[i*ADDR_W +: ADDR_W])) begin
        wbo_fwd_hit[i]                 = 1'b1;
        wbo_fwd_data[i*DATA_W +: DATA_W] = data_p0;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a default instance plus a ZERO_EN=1, CNT_W=4 instance.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [15:0] instr = 16'h0, alu = 16'h0, mem = 16'h0;
  logic [1:0]  sel = 2'b00;
  logic [3:0]  waddr = 4'h0;
  logic        wrn = 1'b1;
  logic [7:0]  faddr = 8'h0;

  logic [1:0]  hit, z_hit;
  logic [31:0] fdata, z_fdata;
  logic [15:0] o_instr, o_data, z_instr, z_data;
  logic [3:0]  o_addr, z_addr;
  logic        o_wrn, z_wrn;
  logic [31:0] o_ret;
  logic [3:0]  z_ret;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .wbi_valid(valid), .wbi_stall(stall), .wbi_flush(flush),
    .wbi_instr(instr), .wbi_alu_data(alu), .wbi_mem_data(mem), .wbi_sel(sel),
    .wbi_wreg_addr(waddr), .wbi_reg_wrn(wrn), .wbi_fwd_addr(faddr),
    .wbo_fwd_hit(hit), .wbo_fwd_data(fdata), .wbo_instr(o_instr),
    .wbo_wreg_addr(o_addr), .wbo_wreg_data(o_data), .wbo_reg_wrn(o_wrn),
    .wbo_retired(o_ret)
  );

  wb_stage #(.CNT_W(4), .ZERO_EN(1), .ZERO_REG(0)) dut_z (
    .clk(clk), .rst(rst), .wbi_valid(valid), .wbi_stall(stall), .wbi_flush(flush),
    .wbi_instr(instr), .wbi_alu_data(alu), .wbi_mem_data(mem), .wbi_sel(sel),
    .wbi_wreg_addr(waddr), .wbi_reg_wrn(wrn), .wbi_fwd_addr(faddr),
    .wbo_fwd_hit(z_hit), .wbo_fwd_data(z_fdata), .wbo_instr(z_instr),
    .wbo_wreg_addr(z_addr), .wbo_wreg_data(z_data), .wbo_reg_wrn(z_wrn),
    .wbo_retired(z_ret)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    #3;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    valid = 1'b0; stall = 1'b0; flush = 1'b0; faddr = 8'h00;
    @(posedge clk);
    #1 rst = 1'b0;
    #2;
    n_cmp++; if (o_wrn !== 1'b1) begin n_err++; $display("FAIL reset_wrn got %b want 1", o_wrn); end
    n_cmp++; if (o_instr !== 16'h0800) begin n_err++; $display("FAIL reset_instr got %h want 0800", o_instr); end
    n_cmp++; if (o_ret !== 32'd0) begin n_err++; $display("FAIL reset_retired got %0d want 0", o_ret); end
    n_cmp++; if ({o_addr, o_data} !== 20'h0) begin n_err++; $display("FAIL reset_addr_data got %h/%h want 0/0", o_addr, o_data); end
    n_cmp++; if (hit !== 2'b00) begin n_err++; $display("FAIL reset_fwd_hit got %b want 00", hit); end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if ({o_wrn, o_instr, o_ret, o_addr, o_data} !== {1'b1, 16'h0800, 32'd0, 4'h0, 16'h0}) begin
        n_err++;
        $display("FAIL idle_hold cyc %0d got wrn=%b instr=%h ret=%0d want 1/0800/0", k, o_wrn, o_instr, o_ret);
      end
    end
  endtask

  task automatic test_data_select();
    logic [15:0] exp_d [4];
    exp_d[0] = 16'hABCD; exp_d[1] = 16'h12F0; exp_d[2] = 16'hFFF0; exp_d[3] = 16'h00F0;
    valid = 1'b1; mem = 16'h12F0; alu = 16'hABCD; waddr = 4'd3; wrn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      instr = 16'h1230 + 16'(k);
      step();
      n_cmp++; if (o_data !== exp_d[k]) begin n_err++; $display("FAIL sel%0d_data got %h want %h", k, o_data, exp_d[k]); end
      n_cmp++; if (o_ret !== 32'(k + 1)) begin n_err++; $display("FAIL sel%0d_retired got %0d want %0d", k, o_ret, k + 1); end
      n_cmp++; if ({o_wrn, o_addr, o_instr} !== {1'b0, 4'd3, 16'h1230 + 16'(k)}) begin
        n_err++; $display("FAIL sel%0d_port got wrn=%b addr=%0d instr=%h", k, o_wrn, o_addr, o_instr);
      end
    end
  endtask

  task automatic test_stall_flush();
    sel = 2'b00; alu = 16'h0042; waddr = 4'd5; wrn = 1'b0; instr = 16'h5005; valid = 1'b1;
    step();
    n_cmp++; if ({o_data, o_addr, o_wrn} !== {16'h0042, 4'd5, 1'b0}) begin
      n_err++; $display("FAIL sf_load got data=%h addr=%0d wrn=%b want 0042/5/0", o_data, o_addr, o_wrn);
    end
    stall = 1'b1; alu = 16'hFFFF; waddr = 4'd9; instr = 16'h9999; wrn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({o_data, o_addr, o_wrn, o_instr, o_ret} !== {16'h0042, 4'd5, 1'b0, 16'h5005, 32'd5}) begin
        n_err++; $display("FAIL stall_hold cyc %0d got data=%h addr=%0d wrn=%b ret=%0d want 0042/5/0/5", k, o_data, o_addr, o_wrn, o_ret);
      end
    end
    flush = 1'b1;
    step();
    n_cmp++;
    if ({o_wrn, o_instr, o_addr, o_data, o_ret} !== {1'b1, 16'h0800, 4'h0, 16'h0, 32'd5}) begin
      n_err++; $display("FAIL flush_over_stall got wrn=%b instr=%h ret=%0d want 1/0800/5", o_wrn, o_instr, o_ret);
    end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_forwarding();
    valid = 1'b1; sel = 2'b00; alu = 16'h7777; waddr = 4'd6; wrn = 1'b0; instr = 16'h6006;
    faddr = {4'd2, 4'd6};
    step();
    n_cmp++; if (hit !== 2'b01) begin n_err++; $display("FAIL fwd_hit got %b want 01", hit); end
    n_cmp++; if (fdata !== 32'h0000_7777) begin n_err++; $display("FAIL fwd_data got %h want 00007777", fdata); end
    faddr = {4'd6, 4'd2};
    #1;
    n_cmp++; if ({hit, fdata} !== {2'b10, 32'h7777_0000}) begin
      n_err++; $display("FAIL fwd_swap got hit=%b data=%h want 10/77770000", hit, fdata);
    end
    wrn = 1'b1;
    step();
    n_cmp++; if ({hit, fdata} !== {2'b00, 32'h0}) begin
      n_err++; $display("FAIL fwd_nowrite got hit=%b data=%h want 00/0", hit, fdata);
    end
    valid = 1'b0;
    step();
    n_cmp++; if ({o_wrn, o_instr, o_ret} !== {1'b1, 16'h0800, 32'd7}) begin
      n_err++; $display("FAIL bubble got wrn=%b instr=%h ret=%0d want 1/0800/7", o_wrn, o_instr, o_ret);
    end
  endtask

  task automatic test_zero_reg();
    valid = 1'b0;
    do_reset();
    valid = 1'b1; sel = 2'b00; alu = 16'h1111; waddr = 4'd0; wrn = 1'b0; instr = 16'h0A0A;
    faddr = {4'd3, 4'd0};
    step();
    n_cmp++; if (z_wrn !== 1'b1) begin n_err++; $display("FAIL zero_wrn got %b want 1", z_wrn); end
    n_cmp++; if (z_hit !== 2'b00) begin n_err++; $display("FAIL zero_hit got %b want 00", z_hit); end
    n_cmp++; if (z_ret !== 4'd1) begin n_err++; $display("FAIL zero_retired got %0d want 1", z_ret); end
    n_cmp++; if ({o_wrn, hit, fdata[15:0]} !== {1'b0, 2'b01, 16'h1111}) begin
      n_err++; $display("FAIL zero_disabled got wrn=%b hit=%b data=%h want 0/01/1111", o_wrn, hit, fdata[15:0]);
    end
  endtask

  task automatic test_wrap();
    valid = 1'b0;
    do_reset();
    valid = 1'b1; waddr = 4'd4; wrn = 1'b1; alu = 16'h0004; instr = 16'h4444;
    for (int k = 0; k < 17; k++) step();
    n_cmp++; if (z_ret !== 4'd1) begin n_err++; $display("FAIL wrap_retired got %0d want 1", z_ret); end
    n_cmp++; if (o_ret !== 32'd17) begin n_err++; $display("FAIL wide_retired got %0d want 17", o_ret); end
    wrn = 1'b0;
    step();
    step();
    n_cmp++; if ({z_ret, o_wrn} !== {4'd3, 1'b0}) begin
      n_err++; $display("FAIL prewrap_state got ret=%0d wrn=%b want 3/0", z_ret, o_wrn);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({z_ret, o_ret} !== {4'd0, 32'd0}) begin
      n_err++; $display("FAIL async_clear got %0d/%0d want 0/0", z_ret, o_ret);
    end
    n_cmp++; if ({o_wrn, hit} !== {1'b1, 2'b00}) begin
      n_err++; $display("FAIL async_wrn got wrn=%b hit=%b want 1/00", o_wrn, hit);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    n_cmp++; if ({z_ret, o_ret} !== {4'd1, 32'd1}) begin
      n_err++; $display("FAIL post_reset_load got %0d/%0d want 1/1", z_ret, o_ret);
    end
  endtask

  initial begin
    test_reset();
    test_data_select();
    test_stall_flush();
    test_forwarding();
    test_zero_reg();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised, registered write-back stage for the 16-bit pipelined CPU. It sits between the MEM stage and the register file. It latches the MEM/WB pipeline register with stall and flush control, and selects and extends the write-back data (ALU result, memory word or memory byte). It drives the register-file write port and supplies bypass data to NUM_FWD read ports in earlier stages. It also keeps a retired-instruction counter.

## Interface
- DATA_W, 16, register/data width (≥ 8)
- ADDR_W, 4, register address width
- INSTR_W, 16, instruction width
- NUM_FWD, 2, number of forwarding lookup ports
- CNT_W, 32, retired-instruction counter width
- ZERO_EN, 0, 1 = writes to ZERO_REG are suppressed
- ZERO_REG, 0, address of hard-wired zero register
- NOP_INSTR, 16'h0800, instruction value held by a bubble
- clk  in  1  stage clock, rising edge
- rst  in  1  asynchronous reset, active-low
- wbi_valid  in  1  MEM stage presents a real instruction
- wbi_stall  in  1  hold stage register
- wbi_flush  in  1  load bubble
- wbi_instr  in  INSTR_W  instruction from MEM
- wbi_alu_data  in  DATA_W  ALU result
- wbi_mem_data  in  DATA_W  memory read data
- wbi_sel  in  2  00 ALU; 01 mem word; 10 mem[7:0] sign-ext; 11 mem[7:0] zero-ext
- wbi_wreg_addr  in  ADDR_W  destination register
- wbi_reg_wrn  in  1  register write enable, active-low
- wbi_fwd_addr  in  NUM_FWD*ADDR_W  lookup addresses, port i at [i*ADDR_W +: ADDR_W]
- wbo_fwd_hit  out  NUM_FWD  port i matches pending write
- wbo_fwd_data  out  NUM_FWD*DATA_W  bypass data, port i at [i*DATA_W +: DATA_W]
- wbo_instr  out  INSTR_W  instruction in WB
- wbo_wreg_addr  out  ADDR_W  register-file write address
- wbo_wreg_data  out  DATA_W  register-file write data
- wbo_reg_wrn  out  1  register-file write enable, active-low
- wbo_retired  out  CNT_W  retired-instruction count

## Operation
- The stage register holds instr, addr, data and wrn. All wbo_* outputs except wbo_fwd_* come directly from flops.
- Each rising edge, in priority order:
  - flush: load a bubble. instr = NOP_INSTR, wrn = 1, addr = 0, data = 0.
  - else stall: hold all stage register values.
  - else wbi_valid = 0: load a bubble.
  - else: load the selected data, wbi_wreg_addr and wbi_instr. wrn = wbi_reg_wrn, forced to 1 when ZERO_EN = 1 and wbi_wreg_addr == ZERO_REG.
- Data select: 10 replicates bit 7 into [DATA_W-1:8]; 11 zero-fills [DATA_W-1:8].
- Retired counter increments by 1 on every edge that loads a real instruction, i.e. not flush, not stall and wbi_valid = 1. This includes instructions that do not write a register and zero-register writes. It wraps modulo 2^CNT_W without saturating.
- Forwarding is combinational from registered state only: wbo_fwd_hit[i] = (wbo_reg_wrn == 0) && (wbi_fwd_addr[i] == wbo_wreg_addr). wbo_fwd_data[i] = wbo_wreg_data when hit, else 0.
- When ZERO_EN = 1, a lookup of ZERO_REG never hits, because such writes are already suppressed.

## Timing
- Reset (rst low, asynchronous): wbo_instr = NOP_INSTR, wbo_wreg_addr = 0, wbo_wreg_data = 0, wbo_reg_wrn = 1, wbo_retired = 0. All wbo_fwd_hit are 0 during reset.
- Reset asserted mid-operation clears a pending write immediately, with no write issued. Deassertion takes effect at the next edge.
- Latency is 1 cycle from MEM inputs to the wbo_* register-file port. The register file writes at the following edge.
- Forwarding has 0-cycle latency relative to the stage register. A lookup in the cycle after a load sees the new value.
- Stall with the outputs holding a write keeps wbo_reg_wrn = 0 asserted. The register file rewrites the same value, which is harmless.
- Simultaneous flush and stall: flush wins.

## Test plan
- Reset then idle: rst low → wbo_reg_wrn = 1, wbo_instr = 16'h0800, wbo_retired = 0. With wbi_valid = 0 for 5 cycles, outputs remain unchanged.
- Data select: mem_data = 16'h12F0, alu_data = 16'hABCD, addr = 3, wrn = 0. sel 00/01/10/11 give 16'hABCD, 16'h12F0, 16'hFFF0 and 16'h00F0 one cycle later, and wbo_retired increments 1 → 4.
- Stall/flush: load addr 5 with data 16'h0042, then stall 3 cycles. Outputs hold and the counter holds. Then assert flush and stall together, giving wrn = 1 and instr = 16'h0800 with no counter increment.
- Forwarding: WB holds a write of 16'h7777 to r6 with wrn = 0. Port 0 looks up 6 → hit = 1, data 16'h7777. Port 1 looks up 2 → hit = 0, data 0. With wrn = 1 held, both ports miss.
- Zero register, ZERO_EN = 1: write r0 with wrn = 0 → wbo_reg_wrn = 1, lookup of 0 misses, counter increments.
- Counter wrap with CNT_W = 4: 17 valid loads → wbo_retired = 1. Asserting rst mid-stream clears it to 0 asynchronously.
